// File: rtl/updn_cnt_mod_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
package updn_cnt_mod_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Terminal condition: at the active top when counting up, at zero when counting down.
    function automatic logic is_term(input logic dir, input logic at_top, input logic at_zero);
        return (dir == DIR_UP) ? at_top : at_zero;
    endfunction

    // Width-agnostic clamp; callers cast operands up to 32 bits and the result back down.
    function automatic logic [31:0] min_w(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/updn_cnt_mod.sv
// Runtime-programmable up/down modulo counter with shadowed top value and parallel load.
// Optional saturate mode is enabled by defining UPDN_CNT_MOD_SAT_EN (adds the sat input).
module updn_cnt_mod
    import updn_cnt_mod_pkg::*;
#(
    parameter int W        = 8,   // 1..32
    parameter int TOP_INIT = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         clr,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         top_wr,
    input  logic [W-1:0] top_val,
`ifdef UPDN_CNT_MOD_SAT_EN
    input  logic         sat,
`endif
    output logic [W-1:0] q,
    output logic         co,
    output logic [W-1:0] top_q,
    output logic         top_pend
);

    localparam logic [W-1:0] TOP_RST = W'(TOP_INIT);
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] shadow;
    logic [W-1:0] q_next;
    logic [W-1:0] top_next;
    logic         sat_mode;
    logic         term;
    logic         wrap;
    logic         apply;

`ifdef UPDN_CNT_MOD_SAT_EN
    assign sat_mode = sat;
`else
    assign sat_mode = 1'b0;
`endif

    assign term = is_term(dir, q == top_q, q == '0);
    assign co   = ce & ~clr & ~load & term;

    // Saturating at term suppresses the wrap, so a pending top can then only land via clr.
    assign wrap     = co & ~sat_mode;
    assign apply    = top_pend & (clr | wrap);
    assign top_next = apply ? shadow : top_q;

    always_comb begin
        // NOTE: default assignment first so every path drives q_next and no latch is inferred.
        q_next = q;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = W'(min_w(32'(load_val), 32'(top_q)));
        end else if (ce && !term) begin
            q_next = (dir == DIR_DN) ? q - ONE : q + ONE;
        end else if (wrap) begin
            // Down-wrap reloads from the post-update top so a new modulo takes effect immediately.
            q_next = (dir == DIR_DN) ? top_next : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            top_q    <= TOP_RST;
            shadow   <= '0;
            top_pend <= 1'b0;
        end else begin
            q     <= q_next;
            top_q <= top_next;
            if (top_wr) begin
                shadow <= top_val;
            end
            // A write colliding with an apply leaves the new value pending.
            top_pend <= top_wr | (top_pend & ~apply);
        end
    end

endmodule

// File: tb/tb_updn_cnt_mod.sv
// Directed table-driven bench for updn_cnt_mod (W=8, TOP_INIT=9); sat checks when UPDN_CNT_MOD_SAT_EN is defined.
module tb_updn_cnt_mod;

    localparam int W = 8;

    typedef struct {
        logic         ce;
        logic         clr;
        logic         dir;
        logic         load;
        logic [W-1:0] load_val;
        logic         top_wr;
        logic [W-1:0] top_val;
        logic         sat;
        logic         exp_co;    // before the edge
        logic [W-1:0] exp_q;     // after the edge
        logic [W-1:0] exp_top;
        logic         exp_pend;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce = 1'b0, clr = 1'b0, dir = 1'b0, load = 1'b0, top_wr = 1'b0, sat = 1'b0;
    logic [W-1:0] load_val = '0, top_val = '0;
    logic [W-1:0] q, top_q;
    logic         co, top_pend;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    updn_cnt_mod #(.W(W), .TOP_INIT(9)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .clr      (clr),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .top_wr   (top_wr),
        .top_val  (top_val),
`ifdef UPDN_CNT_MOD_SAT_EN
        .sat      (sat),
`endif
        .q        (q),
        .co       (co),
        .top_q    (top_q),
        .top_pend (top_pend)
    );

    task automatic check(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic c_e, input logic c_clr, input logic c_dir, input logic c_load,
                       input int lv, input logic tw, input int tv, input logic e_co,
                       input int e_q, input int e_top, input logic e_pend);
        vec_t v;
        v.ce = c_e; v.clr = c_clr; v.dir = c_dir; v.load = c_load;
        v.load_val = W'(lv); v.top_wr = tw; v.top_val = W'(tv); v.sat = 1'b0;
        v.exp_co = e_co; v.exp_q = W'(e_q); v.exp_top = W'(e_top); v.exp_pend = e_pend;
        vecs.push_back(v);
    endtask

    // Drive at negedge, check co just before the edge, check state just after it.
    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        ce = v.ce; clr = v.clr; dir = v.dir; load = v.load; load_val = v.load_val;
        top_wr = v.top_wr; top_val = v.top_val; sat = v.sat;
        #1;
        check("co", idx, int'(co), int'(v.exp_co));
        @(posedge clk);
        #1;
        check("q", idx, int'(q), int'(v.exp_q));
        check("top_q", idx, int'(top_q), int'(v.exp_top));
        check("top_pend", idx, int'(top_pend), int'(v.exp_pend));
    endtask

    task automatic idle_inputs();
        ce = 1'b0; clr = 1'b0; dir = 1'b0; load = 1'b0; top_wr = 1'b0; sat = 1'b0;
        load_val = '0; top_val = '0;
    endtask

`ifdef UPDN_CNT_MOD_SAT_EN
    task automatic sat_step(input logic s, input logic c_clr, input logic tw, input int tv,
                            input logic e_co, input int e_q, input int e_top, input logic e_pend, input int idx);
        vec_t v;
        v.ce = ~c_clr; v.clr = c_clr; v.dir = 1'b0; v.load = 1'b0; v.load_val = '0;
        v.top_wr = tw; v.top_val = W'(tv); v.sat = s;
        v.exp_co = e_co; v.exp_q = W'(e_q); v.exp_top = W'(e_top); v.exp_pend = e_pend;
        apply_vec(v, idx);
    endtask
`endif

    initial begin
        // Up count from reset: 0..9 wrapping, co on q=9.
        for (int i = 0; i < 25; i++) add(1, 0, 0, 0, 0, 0, 0, (i % 10) == 9, (i + 1) % 10, 9, 0);
        // Load clamps to top; load with ce does not count.
        add(0, 0, 0, 1, 200, 0, 0, 0, 9, 9, 0);
        add(1, 0, 0, 1, 4, 0, 0, 0, 4, 9, 0);
        add(0, 0, 0, 1, 200, 0, 0, 0, 9, 9, 0);
        // Down count 9..0 then wrap to 9.
        for (int i = 0; i < 10; i++) add(1, 0, 1, 0, 0, 0, 0, (9 - i) == 0, (i == 9) ? 9 : 8 - i, 9, 0);
        add(0, 0, 1, 1, 4, 0, 0, 0, 4, 9, 0);
        // Shadow top 4 written at q=3, applied at the 9->0 wrap while a new write of 2 lands.
        add(0, 0, 0, 1, 3, 0, 0, 0, 3, 9, 0);
        add(1, 0, 0, 0, 0, 1, 4, 0, 4, 9, 1);
        for (int p = 4; p < 9; p++) add(1, 0, 0, 0, 0, 0, 0, 0, p + 1, 9, 1);
        add(1, 0, 0, 0, 0, 1, 2, 1, 0, 4, 1);
        for (int p = 0; p < 4; p++) add(1, 0, 0, 0, 0, 0, 0, 0, p + 1, 4, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
        // Down wrap with pending top reloads the new top.
        add(0, 0, 0, 0, 0, 1, 5, 0, 0, 2, 1);
        add(1, 0, 1, 0, 0, 0, 0, 1, 5, 5, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 4, 5, 0);
        // Priority: clr+load+ce; load keeps pending; clr applies; last write wins.
        add(1, 1, 0, 1, 3, 0, 0, 0, 0, 5, 0);
        add(0, 0, 0, 0, 0, 1, 7, 0, 0, 5, 1);
        add(0, 0, 0, 1, 3, 0, 0, 0, 3, 5, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        add(0, 0, 0, 0, 0, 1, 6, 0, 0, 7, 1);
        add(0, 0, 0, 0, 0, 1, 8, 0, 0, 7, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 8, 0);
        // Top 0: divide-by-1, co follows ce in both directions.
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        // Top 255: full 8-bit wrap.
        add(1, 0, 0, 0, 0, 1, 255, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 255, 0);
        add(0, 0, 0, 1, 254, 0, 0, 0, 254, 255, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 255, 255, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 255, 0);
        // Direction flip at q=top decrements instead of wrapping.
        add(0, 0, 0, 1, 255, 0, 0, 0, 255, 255, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 254, 255, 0);

        // Reset state.
        #12;
        check("reset_q", 0, int'(q), 0);
        check("reset_top_q", 0, int'(top_q), 9);
        check("reset_pend", 0, int'(top_pend), 0);
        check("reset_co", 0, int'(co), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Asynchronous reset between edges discards a pending top.
        @(negedge clk);
        idle_inputs();
        ce = 1'b1; top_wr = 1'b1; top_val = 8'd3;
        @(posedge clk);
        #1;
        check("async_pre_pend", 0, int'(top_pend), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_q", 0, int'(q), 0);
        check("async_top_q", 0, int'(top_q), 9);
        check("async_pend", 0, int'(top_pend), 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        ce = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_q", 0, int'(q), 1);
        check("post_reset_top_q", 0, int'(top_q), 9);

`ifdef UPDN_CNT_MOD_SAT_EN
        // Saturate: hold at 9 with co, pending top waits for clr, then normal wrap with sat=0.
        sat_step(1, 1, 0, 0, 0, 0, 9, 0, 0);
        for (int p = 0; p < 9; p++) sat_step(1, 0, 0, 0, 0, p + 1, 9, 0, p + 1);
        sat_step(1, 0, 0, 0, 1, 9, 9, 0, 10);
        sat_step(1, 0, 0, 0, 1, 9, 9, 0, 11);
        sat_step(1, 0, 1, 4, 1, 9, 9, 1, 12);
        sat_step(1, 0, 0, 0, 1, 9, 9, 1, 13);
        sat_step(1, 1, 0, 0, 0, 0, 4, 0, 14);
        for (int p = 0; p < 4; p++) sat_step(0, 0, 0, 0, 0, p + 1, 4, 0, 15 + p);
        sat_step(0, 0, 0, 0, 1, 0, 4, 0, 19);
`endif

        @(negedge clk);
        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
